uriscv_muldiv_arb: RTL and testbench
====================================

// Module: uriscv_muldiv_arb
// PURPOSE
//  Shares one uriscv_muldiv unit between two requesters (e.g. core pipeline and coprocessor/debug port).
//  Arbitrates round-robin, sequences exactly one operation at a time into the unit and returns the result
//  with the requester id and tag. Enforces a watchdog so that a lost md_ready_i cannot hang either requester.
// PARAMETERS
//  TAG_W        4   width of per-request tag echoed on response
//  TIMEOUT_CYC  64  max cycles in WAIT before error response (must exceed 36)
// PORTS
//  clk_i          in   1        clock, all flops rising edge
//  rst_ni         in   1        reset, asynchronous assert, active-low
//  req_valid_i    in   2        request valid, bit n = requester n
//  req_ready_o    out  2        request accepted (one-hot, combinational in IDLE)
//  req_op_i       in   6        per requester [3n+2:3n] funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  req_a_i        in   64       operand A, [32n+31:32n]
//  req_b_i        in   64       operand B, [32n+31:32n]
//  req_tag_i      in   2*TAG_W  request tag, [TAG_W*n+:TAG_W]
//  resp_valid_o   out  1        response valid
//  resp_ready_i   in   1        response accepted
//  resp_id_o      out  1        requester owning response
//  resp_tag_o     out  TAG_W    echoed tag
//  resp_result_o  out  32       result
//  resp_err_o     out  1        1 = watchdog timeout, result forced 0
//  md_valid_o     out  1        to muldiv valid_i
//  md_inst_o      out  8        one-hot to muldiv inst_*: bit k = funct3 k (bit0 mul ... bit7 remu)
//  md_ra_o        out  32       to muldiv operand_ra_i
//  md_rb_o        out  32       to muldiv operand_rb_i
//  md_stall_i     in   1        from muldiv stall_o
//  md_ready_i     in   1        from muldiv ready_o (1-cycle pulse)
//  md_result_i    in   32       from muldiv result_o
// BEHAVIOUR
//  Reset: state IDLE, last-grant ptr = 1 (requester 0 wins first tie), all outputs 0, md_inst_o = 0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one op outstanding, no pipelining.
//  IDLE: if any req_valid_i, grant g (single request: that one; both: requester != last-grant ptr).
//   req_ready_o[g]=1 same cycle; capture op/a/b/tag/id into regs, update ptr=g, go ISSUE. Else stay.
//   req_ready_o = 0 in all other states.
//  ISSUE: md_valid_o=1, md_inst_o=1<<op, md_ra_o/md_rb_o from regs. If !md_stall_i go WAIT next cycle
//   (md_valid_o high exactly one cycle); if md_stall_i hold ISSUE with same outputs.
//  md_valid_o, md_inst_o, md_ra_o, md_rb_o are 0 outside ISSUE (registered, glitch-free).
//  WAIT: count cycles from 1. On md_ready_i: latch md_result_i, err=0, go RESP.
//   If count reaches TIMEOUT_CYC without md_ready_i: result=0, err=1, go RESP.
//   md_ready_i in the same cycle the count expires wins (err=0).
//  RESP: resp_valid_o=1 with id/tag/result/err stable until resp_ready_i; on handshake go IDLE.
//   New grant earliest the cycle after the response handshake.
//  md_ready_i outside WAIT (late pulse after timeout) ignored, no state change.
//  Latency accept->resp_valid_o (ideal unit, no stall): MUL* 4 cycles, DIV*/REM* 36 cycles.
//  Requester must hold req_* stable while req_valid_i=1 and not accepted; arbiter does not buffer.
//  Reset asserted mid-operation: immediate return to IDLE, outputs cleared; in-flight op is dropped,
//   no response produced. The muldiv unit shares this reset domain.
//  No arithmetic here; operands pass through unchanged; signedness is set by md_inst_o only.
// TESTING
//  R0 MUL a=7 b=6 tag=3 alone -> req_ready_o=01 same cycle; resp at +4: id0 tag3 result=42 err0.
//  R1 DIV a=-20 b=3 -> resp at +36 result=0xFFFFFFFA; REM same operands -> 0xFFFFFFFE; DIVU b=0 -> 0xFFFFFFFF.
//  Both valid every cycle after reset -> grants 0,1,0,1 alternate; resp_id_o matches; tags preserved.
//  resp_ready_i low 10 cycles in RESP -> resp_* stable, req_ready_o=00, md_valid_o=0 throughout.
//  md_ready_i tied 0 -> resp_err_o=1, result 0 after TIMEOUT_CYC in WAIT; later md_ready_i pulse ignored.
//  rst_ni low in WAIT during DIV -> all outputs 0 asynchronously; after release R0 MUL 3*5 -> 15 at +4.

Source files
------------

// File: rtl/uriscv_muldiv_arb.sv
// Two-requester round-robin front end for a single uriscv_muldiv unit.
// One operation in flight at a time; a watchdog turns a lost md_ready_i into an error response.
module uriscv_muldiv_arb #(
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [5:0]         req_op_i,
    input  logic [63:0]        req_a_i,
    input  logic [63:0]        req_b_i,
    input  logic [2*TAG_W-1:0] req_tag_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic               resp_id_o,
    output logic [TAG_W-1:0]   resp_tag_o,
    output logic [31:0]        resp_result_o,
    output logic               resp_err_o,
    output logic               md_valid_o,
    output logic [7:0]         md_inst_o,
    output logic [31:0]        md_ra_o,
    output logic [31:0]        md_rb_o,
    input  logic               md_stall_i,
    input  logic               md_ready_i,
    input  logic [31:0]        md_result_i,
    output logic [1:0]         dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a requester holds its payload stable while valid=1 and not yet accepted.
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q;
    logic [2:0]         op_q;
    logic [31:0]        a_q, b_q;
    logic [TAG_W-1:0]   tag_q;
    logic               id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        result_q;
    logic               err_q;
    logic               md_valid_q;
    logic [7:0]         md_inst_q;
    logic [31:0]        md_ra_q, md_rb_q;

    logic               any_req;
    logic               grant;
    logic [2:0]         sel_op, issue_op;
    logic [31:0]        sel_a, sel_b, issue_a, issue_b;
    logic [TAG_W-1:0]   sel_tag;
    logic               timeout;

    // On a tie the requester that did not win last time gets the grant.
    assign any_req  = |req_valid_i;
    assign grant    = (&req_valid_i) ? ~ptr_q : req_valid_i[1];
    assign sel_op   = grant ? req_op_i[5:3]   : req_op_i[2:0];
    assign sel_a    = grant ? req_a_i[63:32]  : req_a_i[31:0];
    assign sel_b    = grant ? req_b_i[63:32]  : req_b_i[31:0];
    assign sel_tag  = grant ? req_tag_i[2*TAG_W-1:TAG_W] : req_tag_i[TAG_W-1:0];
    assign issue_op = (state_q == S_IDLE) ? sel_op : op_q;
    assign issue_a  = (state_q == S_IDLE) ? sel_a  : a_q;
    assign issue_b  = (state_q == S_IDLE) ? sel_b  : b_q;
    assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req)                 state_d = S_ISSUE;
            S_ISSUE: if (!md_stall_i)             state_d = S_WAIT;
            S_WAIT:  if (md_ready_i || timeout)   state_d = S_RESP;
            S_RESP:  if (resp_ready_i)            state_d = S_IDLE;
            default:                              state_d = S_IDLE;
        endcase
    end

    // Unit-facing outputs come straight from flops, loaded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            id_q       <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            md_valid_q <= 1'b0;
            md_inst_q  <= '0;
            md_ra_q    <= '0;
            md_rb_q    <= '0;
        end else begin
            md_valid_q <= (state_d == S_ISSUE);
            md_inst_q  <= (state_d == S_ISSUE) ? (8'd1 << issue_op) : 8'd0;
            md_ra_q    <= (state_d == S_ISSUE) ? issue_a : 32'd0;
            md_rb_q    <= (state_d == S_ISSUE) ? issue_b : 32'd0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        op_q  <= sel_op;
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        tag_q <= sel_tag;
                        id_q  <= grant;
                        ptr_q <= grant;
                    end
                end
                S_ISSUE: cnt_q <= CNT_W'(1);
                S_WAIT: begin
                    // A ready arriving on the expiry cycle still counts as a real result.
                    if (md_ready_i) begin
                        result_q <= md_result_i;
                        err_q    <= 1'b0;
                    end else if (timeout) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready_o   = 2'b00;
        resp_valid_o  = 1'b0;
        resp_id_o     = 1'b0;
        resp_tag_o    = '0;
        resp_result_o = '0;
        resp_err_o    = 1'b0;
        if (state_q == S_IDLE && rst_ni && any_req)
            req_ready_o = grant ? 2'b10 : 2'b01;
        if (state_q == S_RESP) begin
            resp_valid_o  = 1'b1;
            resp_id_o     = id_q;
            resp_tag_o    = tag_q;
            resp_result_o = result_q;
            resp_err_o    = err_q;
        end
    end

    assign md_valid_o  = md_valid_q;
    assign md_inst_o   = md_inst_q;
    assign md_ra_o     = md_ra_q;
    assign md_rb_o     = md_rb_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uriscv_muldiv_arb.sv
// Bench for uriscv_muldiv_arb: behavioural muldiv unit, arithmetic reference model and
// response scoreboard, driven by directed and randomized steps.
module tb_uriscv_muldiv_arb;

    localparam int TAG_W       = 4;
    localparam int TIMEOUT_CYC = 64;
    // Ideal unit: ready pulse this many cycles after the last issue cycle.
    localparam int LAT_MUL     = 2;
    localparam int LAT_DIV     = 34;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  req_valid_i = '0;
    logic [1:0]  req_ready_o;
    logic [5:0]  req_op_i = '0;
    logic [63:0] req_a_i = '0;
    logic [63:0] req_b_i = '0;
    logic [7:0]  req_tag_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic        resp_id_o;
    logic [3:0]  resp_tag_o;
    logic [31:0] resp_result_o;
    logic        resp_err_o;
    logic        md_valid_o;
    logic [7:0]  md_inst_o;
    logic [31:0] md_ra_o, md_rb_o;
    logic        md_stall_i = 1'b0;
    logic        md_ready_i = 1'b0;
    logic [31:0] md_result_i = '0;
    logic [1:0]  dbg_state_o;

    uriscv_muldiv_arb #(.TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
        .resp_tag_o(resp_tag_o), .resp_result_o(resp_result_o), .resp_err_o(resp_err_o),
        .md_valid_o(md_valid_o), .md_inst_o(md_inst_o), .md_ra_o(md_ra_o), .md_rb_o(md_rb_o),
        .md_stall_i(md_stall_i), .md_ready_i(md_ready_i), .md_result_i(md_result_i),
        .dbg_state_o(dbg_state_o)
    );

    // Clock: 10-time-unit period; bench drives and samples on the falling edge.
    initial forever #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [37:0] exp_q[$];          // {id, tag, err, result}
    int          stall_budget = 0;
    int          unit_delay = 0;    // 0 = natural latency, <0 = unit never answers
    bit          inject_late = 0;
    int          mdv_cnt = 0;
    bit          pending = 0;
    int          remaining = 0;
    logic [31:0] pend_res = '0;
    logic [2:0]  dec = '0;
    logic [2:0]  rq_op[2];
    logic [31:0] rq_a[2], rq_b[2];
    logic [3:0]  rq_tag[2];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6: return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Behavioural muldiv unit: decodes the one-hot op, answers with a one-cycle ready pulse.
    always @(negedge clk) begin
        md_ready_i  = 1'b0;
        md_result_i = '0;
        if (!rst_ni) begin
            pending    = 0;
            md_stall_i = 1'b0;
        end else begin
            if (pending) begin
                remaining--;
                if (remaining == 0) begin
                    md_ready_i  = 1'b1;
                    md_result_i = pend_res;
                    pending     = 0;
                end
            end
            if (inject_late) begin
                md_ready_i  = 1'b1;
                md_result_i = 32'h1234_5678;
                inject_late = 0;
            end
            md_stall_i = 1'b0;
            if (md_valid_o) begin
                mdv_cnt++;
                if (stall_budget > 0) begin
                    md_stall_i = 1'b1;
                    stall_budget--;
                end else begin
                    dec = '0;
                    for (int k = 0; k < 8; k++) if (md_inst_o[k]) dec = 3'(k);
                    chk("md_inst_onehot", 64'($countones(md_inst_o)), 64'd1);
                    pend_res = ref_md(dec, md_ra_o, md_rb_o);
                    if (unit_delay < 0) pending = 0;
                    else begin
                        pending   = 1;
                        remaining = (unit_delay > 0) ? unit_delay : ((dec >= 3'd4) ? LAT_DIV : LAT_MUL);
                    end
                end
            end
        end
    end

    // Scoreboard: every accepted response is compared with the oldest expectation.
    always @(negedge clk) begin
        logic [37:0] e;
        #1;
        if (rst_ni && resp_valid_o && resp_ready_i) begin
            if (exp_q.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("resp", {resp_id_o, resp_tag_o, resp_err_o, resp_result_o}, e);
            end
        end
    end

    task automatic drive_req(input int id, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] tag);
        rq_op[id] = op; rq_a[id] = a; rq_b[id] = b; rq_tag[id] = tag;
        req_op_i  = {rq_op[1], rq_op[0]};
        req_a_i   = {rq_a[1], rq_a[0]};
        req_b_i   = {rq_b[1], rq_b[0]};
        req_tag_i = {rq_tag[1], rq_tag[0]};
    endtask

    task automatic wait_and_ack(input int rdly, output int lat);
        lat = 1;
        while (resp_valid_o !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        repeat (rdly) @(negedge clk);
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
    endtask

    // Single request; d: 0 natural unit latency, >0 forced delay, <0 unit silent.
    task automatic run_op(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input int stall, input int rdly, input int d);
        int dd, exp_lat, lat;
        bit err;
        dd      = (d == 0) ? ((op >= 3'd4) ? LAT_DIV : LAT_MUL) : d;
        err     = (d < 0) || (dd > TIMEOUT_CYC);
        // accept cycle, issue cycle(s), then WAIT cycles counted from 1
        exp_lat = stall + 2 + (err ? TIMEOUT_CYC : dd);
        @(negedge clk);
        stall_budget = stall;
        unit_delay   = d;
        mdv_cnt      = 0;
        drive_req(id, op, a, b, tag);
        req_valid_i = 2'(1 << id);
        #1 chk("grant_single", 64'(req_ready_o), 64'(1 << id));
        exp_q.push_back({1'(id), tag, err, err ? 32'd0 : ref_md(op, a, b)});
        @(negedge clk);
        req_valid_i = 2'b00;
        wait_and_ack(rdly, lat);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("issue_cycles", 64'(mdv_cnt), 64'(stall + 1));
    endtask

    task automatic async_reset();
        #2 rst_ni = 1'b0;
        exp_q.delete();
        stall_budget = 0;
        #1;
    endtask

    initial begin
        int lat, cyc, last_g, exp_g;
        logic [37:0] e;
        for (int i = 0; i < 2; i++) drive_req(i, 3'd0, 32'd0, 32'd0, 4'd0);

        // Reset state, with both requesters asserting valid.
        req_valid_i = 2'b11;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_md_valid", 64'(md_valid_o), 64'd0);
        chk("rst_md_inst", 64'(md_inst_o), 64'd0);
        chk("rst_resp_result", 64'(resp_result_o), 64'd0);
        req_valid_i = 2'b00;
        @(negedge clk);
        rst_ni = 1'b1;

        run_op(0, 3'd0, 32'd7, 32'd6, 4'd3, 0, 0, 0);
        run_op(0, 3'd4, 32'hFFFF_FFEC, 32'd3, 4'd5, 0, 0, 0);
        run_op(1, 3'd6, 32'hFFFF_FFEC, 32'd3, 4'd6, 0, 1, 0);
        run_op(1, 3'd5, 32'd1234, 32'd0, 4'd7, 0, 0, 0);
        run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 1, 0, 0);

        for (int i = 0; i < 16; i++)
            run_op($urandom_range(0, 1), 3'($urandom_range(0, 7)), pick(), pick(),
                   4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3), 0);

        // Both requesters continuously valid after reset: grants alternate, starting at 0.
        @(negedge clk);
        async_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        unit_delay = 0;
        resp_ready_i = 1'b1;
        for (int i = 0; i < 2; i++)
            drive_req(i, 3'($urandom_range(0, 7)), pick(), pick(), 4'($urandom_range(0, 15)));
        req_valid_i = 2'b11;
        last_g = 1;
        #1;
        for (int g = 0; g < 4; g++) begin
            cyc = 0;
            while (req_ready_o == 2'b00 && cyc < 200) begin @(negedge clk); #1; cyc++; end
            chk("grant_wait", 64'(cyc < 200), 64'd1);
            exp_g = (req_valid_i == 2'b11) ? 1 - last_g : (req_valid_i[1] ? 1 : 0);
            chk("grant_rr", 64'(req_ready_o), 64'(1 << exp_g));
            exp_q.push_back({1'(exp_g), rq_tag[exp_g], 1'b0, ref_md(rq_op[exp_g], rq_a[exp_g], rq_b[exp_g])});
            last_g = exp_g;
            @(negedge clk);
            if (g == 3) req_valid_i = 2'b00;
            else drive_req(exp_g, 3'($urandom_range(0, 7)), pick(), pick(), 4'($urandom_range(0, 15)));
            #1;
        end
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin @(negedge clk); cyc++; end
        chk("rr_drain", 64'(exp_q.size()), 64'd0);
        resp_ready_i = 1'b0;

        // Response held for 10 cycles while requester 1 waits.
        @(negedge clk);
        stall_budget = 0;
        unit_delay = 0;
        drive_req(0, 3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'd9);
        req_valid_i = 2'b01;
        #1 chk("grant_hold", 64'(req_ready_o), 64'd1);
        e = {1'b0, 4'd9, 1'b0, ref_md(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D)};
        exp_q.push_back(e);
        @(negedge clk);
        drive_req(1, 3'd7, 32'd100, 32'd7, 4'hA);
        req_valid_i = 2'b10;
        cyc = 0;
        while (resp_valid_o !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        for (int i = 0; i < 10; i++) begin
            chk("hold_resp", {resp_valid_o, resp_id_o, resp_tag_o, resp_err_o, resp_result_o}, {1'b1, e});
            chk("hold_req_ready", 64'(req_ready_o), 64'd0);
            chk("hold_md_valid", 64'({md_valid_o, md_inst_o}), 64'd0);
            @(negedge clk);
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        #1 chk("grant_after_resp", 64'(req_ready_o), 64'd2);
        exp_q.push_back({1'b1, 4'hA, 1'b0, ref_md(3'd7, 32'd100, 32'd7)});
        @(negedge clk);
        req_valid_i = 2'b00;
        wait_and_ack(0, lat);
        chk("hold_second_lat", 64'(lat), 64'(1 + LAT_DIV + 1));

        // Watchdog: silent unit, ready on the expiry cycle, ready one cycle too late.
        run_op(0, 3'd4, 32'd100, 32'd7, 4'd1, 0, 0, -1);
        @(negedge clk);
        inject_late = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_ignored", 64'({resp_valid_o, req_ready_o, md_valid_o}), 64'd0);
        end
        run_op(1, 3'd0, 32'd9, 32'd9, 4'd2, 0, 0, TIMEOUT_CYC);
        run_op(0, 3'd1, 32'h8000_0000, 32'd3, 4'd4, 0, 0, TIMEOUT_CYC + 1);
        run_op(1, 3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'd5, 2, 0, 0);

        // Asynchronous reset while stalled in issue.
        @(negedge clk);
        stall_budget = 100;
        drive_req(0, 3'd2, 32'h55, 32'h66, 4'd6);
        req_valid_i = 2'b01;
        @(negedge clk);
        req_valid_i = 2'b00;
        @(negedge clk);
        chk("stall_md_inst", 64'({md_valid_o, md_inst_o}), 64'h104);
        async_reset();
        chk("arst_issue_md", {md_valid_o, md_inst_o, md_ra_o, md_rb_o}, 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Asynchronous reset in WAIT during a divide; the op must vanish.
        @(negedge clk);
        drive_req(1, 3'd4, 32'd1000, 32'd10, 4'd7);
        req_valid_i = 2'b10;
        @(negedge clk);
        req_valid_i = 2'b00;
        repeat (10) @(negedge clk);
        chk("wait_quiet", 64'({resp_valid_o, md_valid_o, req_ready_o}), 64'd0);
        async_reset();
        chk("arst_wait", 64'({resp_valid_o, md_valid_o, req_ready_o, md_inst_o}), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        run_op(0, 3'd0, 32'd3, 32'd5, 4'd3, 0, 0, 0);

        // Asynchronous reset while a response is being presented.
        @(negedge clk);
        drive_req(0, 3'd0, 32'd11, 32'd13, 4'hC);
        req_valid_i = 2'b01;
        @(negedge clk);
        req_valid_i = 2'b00;
        cyc = 0;
        while (resp_valid_o !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        chk("resp_before_rst", 64'({resp_valid_o, resp_tag_o, resp_result_o}), {27'd0, 1'b1, 4'hC, 32'd143});
        async_reset();
        chk("arst_resp", 64'({resp_valid_o, resp_id_o, resp_tag_o, resp_err_o, resp_result_o}), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        run_op(1, 3'd7, 32'd17, 32'd5, 4'hF, 0, 2, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
